// File: rtl/disp_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
// Glyphs are stored active-high in a..g order (bit6 = a, bit0 = g).
package disp_pkg;

    localparam logic [6:0] GLYPH_0 = 7'b1111110;
    localparam logic [6:0] GLYPH_1 = 7'b0110000;
    localparam logic [6:0] GLYPH_2 = 7'b1101101;
    localparam logic [6:0] GLYPH_3 = 7'b1111001;
    localparam logic [6:0] GLYPH_4 = 7'b0110011;
    localparam logic [6:0] GLYPH_5 = 7'b1011011;
    localparam logic [6:0] GLYPH_6 = 7'b1011111;
    localparam logic [6:0] GLYPH_7 = 7'b1110000;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1111011;
    localparam logic [6:0] GLYPH_A = 7'b1110111;
    localparam logic [6:0] GLYPH_B = 7'b0011111;
    localparam logic [6:0] GLYPH_C = 7'b1001110;
    localparam logic [6:0] GLYPH_D = 7'b0111101;
    localparam logic [6:0] GLYPH_E = 7'b1001111;
    localparam logic [6:0] GLYPH_F = 7'b1000111;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Converts an active-high segment pattern to the pin level of the board.
    function automatic logic [6:0] apply_pol(input logic [6:0] s, input bit active_low);
        return active_low ? ~s : s;
    endfunction

endpackage

// File: rtl/module_seg7_hex.sv
// Combinational hex-to-7-segment decoder, active-high output in a..g order.
module module_seg7_hex
    import disp_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Table lookup from the 4-bit nibble to its glyph
    always_comb begin
        seg_o = SEG_BLANK;
        unique case (hex_i)
            4'h0: seg_o = GLYPH_0;
            4'h1: seg_o = GLYPH_1;
            4'h2: seg_o = GLYPH_2;
            4'h3: seg_o = GLYPH_3;
            4'h4: seg_o = GLYPH_4;
            4'h5: seg_o = GLYPH_5;
            4'h6: seg_o = GLYPH_6;
            4'h7: seg_o = GLYPH_7;
            4'h8: seg_o = GLYPH_8;
            4'h9: seg_o = GLYPH_9;
            4'hA: seg_o = GLYPH_A;
            4'hB: seg_o = GLYPH_B;
            4'hC: seg_o = GLYPH_C;
            4'hD: seg_o = GLYPH_D;
            4'hE: seg_o = GLYPH_E;
            4'hF: seg_o = GLYPH_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/module_disp_scan.sv
// Time-multiplexed N-digit 7-segment driver. A prescaler paces one digit per
// slot; the displayed word is latched into shadow registers only at the frame
// wrap so a frame never mixes old and new digits.
module module_disp_scan
    import disp_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 27000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit LZ_BLANK       = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic                    en,
    output logic [6:0]              seg,
    output logic                    dp_o,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_tick
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [PRE_W-1:0]    LAST_PRE = PRE_W'(REFRESH_DIV - 1);
    localparam logic [6:0]          SEG_OFF  = apply_pol(SEG_BLANK, SEG_ACTIVE_LOW);
    localparam logic                DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [N_DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    // Reject configurations the scan logic was not built for
    if (N_DIGITS < 1 || N_DIGITS > 8) begin : gBadDigits
        $error("module_disp_scan: N_DIGITS must be in 1..8");
    end
    if (REFRESH_DIV < 1) begin : gBadDiv
        $error("module_disp_scan: REFRESH_DIV must be at least 1");
    end

    logic [PRE_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] shadowVal_q, shadowVal_d;
    logic [N_DIGITS-1:0]   shadowDp_q, shadowDp_d;
    logic                  frameTick_q, frameTick_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dpOut_q, dpOut_d;
    logic [N_DIGITS-1:0]   an_q, an_d;

    logic                  slotTick;
    logic                  frameWrap;
    logic [3:0]            curHex;
    logic                  curDp;
    logic                  curLeadZero;
    logic                  zeroRun;
    logic [N_DIGITS-1:0]   anOneHot;
    logic [6:0]            glyph;
    logic [6:0]            segActive;

    // Scan timing: prescaler paces slots, idx walks digits, shadow reloads at frame wrap
    always_comb begin
        slotTick    = (presc_q == LAST_PRE);
        frameWrap   = slotTick && (idx_q == LAST_IDX);
        presc_d     = slotTick ? '0 : presc_q + 1'b1;
        idx_d       = idx_q;
        if (slotTick) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        shadowVal_d = frameWrap ? value : shadowVal_q;
        shadowDp_d  = frameWrap ? dp : shadowDp_q;
        frameTick_d = frameWrap;
    end

    // Pick the active shadow digit and decide whether it is a leading zero;
    // zeroRun accumulates "all digits from the top down to here are zero"
    always_comb begin
        curHex      = 4'h0;
        curDp       = 1'b0;
        curLeadZero = 1'b0;
        zeroRun     = 1'b1;
        anOneHot    = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zeroRun     = zeroRun & (shadowVal_q[4*i +: 4] == 4'h0);
            anOneHot[i] = (idx_q == IDX_W'(i));
            if (idx_q == IDX_W'(i)) begin
                curHex      = shadowVal_q[4*i +: 4];
                curDp       = shadowDp_q[i];
                curLeadZero = zeroRun && (i != 0);
            end
        end
    end

    module_seg7_hex uDecoder (
        .hex_i (curHex),
        .seg_o (glyph)
    );

    // Output pin levels: blanking first, then enable gating, polarity applied last
    always_comb begin
        segActive = (LZ_BLANK && curLeadZero) ? SEG_BLANK : glyph;
        seg_d     = SEG_OFF;
        dpOut_d   = DP_OFF;
        an_d      = AN_OFF;
        if (en) begin
            seg_d   = apply_pol(segActive, SEG_ACTIVE_LOW);
            dpOut_d = curDp ^ SEG_ACTIVE_LOW;
            an_d    = anOneHot ^ AN_OFF;
        end
    end

    // State and output registers with synchronous reset to the idle display
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            idx_q       <= '0;
            shadowVal_q <= '0;
            shadowDp_q  <= '0;
            frameTick_q <= 1'b0;
            seg_q       <= SEG_OFF;
            dpOut_q     <= DP_OFF;
            an_q        <= AN_OFF;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            shadowVal_q <= shadowVal_d;
            shadowDp_q  <= shadowDp_d;
            frameTick_q <= frameTick_d;
            seg_q       <= seg_d;
            dpOut_q     <= dpOut_d;
            an_q        <= an_d;
        end
    end

    assign seg        = seg_q;
    assign dp_o       = dpOut_q;
    assign an         = an_q;
    assign frame_tick = frameTick_q;

endmodule
